// File: rtl/control_sequencer_if.sv
// control_sequencer_if: decode-stage bundle between fetch/decode, the control
// sequencer and execute.
//   master : fetch/decode side; drives opcode, instr_valid, flush and the data
//            bus bus_ready; receives the registered control set.
//   slave  : the control sequencer; the mirror image of master.
interface control_sequencer_if;
  logic [6:0] opcode;
  logic       instr_valid;
  logic       flush;
  logic       bus_ready;

  logic [2:0] cs_imm_src;
  logic       cs_reg_write;
  logic       cs_reg_1_zero;
  logic       cs_alu_src;
  logic [1:0] cs_alu_control;
  logic [1:0] cs_mem_to_reg;
  logic [1:0] cs_branch_op;
  logic       cs_bus_read;
  logic       cs_bus_write;
  logic       cs_stall;
  logic       cs_illegal;
  logic       cs_bus_error;

  modport master (
    output opcode, instr_valid, flush, bus_ready,
    input  cs_imm_src, cs_reg_write, cs_reg_1_zero, cs_alu_src, cs_alu_control,
           cs_mem_to_reg, cs_branch_op, cs_bus_read, cs_bus_write, cs_stall,
           cs_illegal, cs_bus_error
  );

  modport slave (
    input  opcode, instr_valid, flush, bus_ready,
    output cs_imm_src, cs_reg_write, cs_reg_1_zero, cs_alu_src, cs_alu_control,
           cs_mem_to_reg, cs_branch_op, cs_bus_read, cs_bus_write, cs_stall,
           cs_illegal, cs_bus_error
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: registered RV32I opcode decoder forming the ID/EX
// boundary, with a memory-wait sequencer (fixed stall counts or bus
// handshake with timeout), flush squash, illegal-opcode pulse and a sticky
// bus-timeout flag.
//   clk   : core clock, rising edge
//   reset : asynchronous, active-high; returns all outputs to the NOP encoding
//   bus   : control_sequencer_if.slave (opcode/valid/flush/bus_ready in,
//           cs_* control set, cs_stall, cs_illegal, cs_bus_error out)
//
// state    | meaning
// ST_RUN   | decoding; a new instruction is captured every clock
// ST_WAIT  | memory op outstanding; control held, fetch stalled
// ST_ERROR | bus timed out; NOP outputs, stalled until reset
module control_sequencer #(
  parameter int BUS_HANDSHAKE      = 0,
  parameter int LOAD_STALL_CYCLES  = 1,
  parameter int STORE_STALL_CYCLES = 0,
  parameter int TIMEOUT_CYCLES     = 15,
  parameter int CNT_W              = 4
) (
  input logic clk,
  input logic reset,
  control_sequencer_if.slave bus
);

  localparam bit HS = (BUS_HANDSHAKE != 0);

  localparam logic [6:0] OP_ARITHR = 7'b0110011;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;
  localparam logic [6:0] OP_CONDBR = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Counter preloads: fixed mode counts down to zero, handshake mode counts
  // up towards the timeout limit.
  localparam logic [CNT_W-1:0] LOAD_LAST    = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] STORE_LAST   = CNT_W'(STORE_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [2:0] imm_src;
    logic       reg_write;
    logic       reg_1_zero;
    logic       alu_src;
    logic [1:0] alu_control;
    logic [1:0] mem_to_reg;
    logic [1:0] branch_op;
    logic       bus_read;
    logic       bus_write;
  } ctrl_t;

  localparam ctrl_t NOP = '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  ctrl_t            ctrl_q;
  logic             illegal_q;
  logic             bus_error_q;

  ctrl_t            dec;
  logic             known;
  ctrl_t            cap_ctrl;
  logic             cap_illegal;
  logic             cap_wait;
  logic [CNT_W-1:0] cap_cnt;
  logic             wait_done;
  logic             capture;

  always_comb begin
    dec   = NOP;
    known = 1'b1;
    case (bus.opcode)
      OP_ARITHR: dec = ctrl_t'(14'b000_1_0_0_11_00_00_0_0);
      OP_ARITHI: dec = ctrl_t'(14'b001_1_0_1_10_00_00_0_0);
      OP_CONDBR: dec = ctrl_t'(14'b011_0_0_0_01_00_01_0_0);
      OP_JAL:    dec = ctrl_t'(14'b100_1_1_1_00_10_10_0_0);
      OP_JALR:   dec = ctrl_t'(14'b001_1_0_1_00_10_11_0_0);
      OP_LOAD:   dec = ctrl_t'(14'b001_1_0_1_00_01_00_1_0);
      OP_STORE:  dec = ctrl_t'(14'b010_0_0_1_00_00_00_0_1);
      OP_LUI:    dec = ctrl_t'(14'b000_1_1_1_00_00_00_0_0);
      OP_AUIPC:  dec = ctrl_t'(14'b101_1_0_1_00_11_00_0_0);
      default:   known = 1'b0;
    endcase
  end

  // What would be registered if an instruction is taken this edge.
  // Priority: flush > !instr_valid > decode.
  always_comb begin
    cap_ctrl    = NOP;
    cap_illegal = 1'b0;
    cap_wait    = 1'b0;
    cap_cnt     = '0;
    if (bus.instr_valid && !bus.flush) begin
      if (!known) begin
        cap_illegal = 1'b1;
      end else begin
        cap_ctrl = dec;
        if (bus.opcode == OP_LOAD) begin
          cap_wait = HS || (LOAD_STALL_CYCLES != 0);
          cap_cnt  = HS ? '0 : LOAD_LAST;
        end else if (bus.opcode == OP_STORE) begin
          cap_wait = HS || (STORE_STALL_CYCLES != 0);
          cap_cnt  = HS ? '0 : STORE_LAST;
        end
      end
    end
  end

  // Leaving WAIT captures the next instruction on the same edge, so
  // back-to-back memory ops stall without a bubble. Ready beats timeout.
  assign wait_done = HS ? bus.bus_ready : (cnt == '0);
  assign capture   = (state == ST_RUN) || ((state == ST_WAIT) && wait_done);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      cnt         <= '0;
      ctrl_q      <= NOP;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else if (capture) begin
      ctrl_q    <= cap_ctrl;
      illegal_q <= cap_illegal;
      cnt       <= cap_cnt;
      state     <= cap_wait ? ST_WAIT : ST_RUN;
    end else begin
      illegal_q <= 1'b0;
      if (state == ST_WAIT) begin
        if (HS && (cnt == TIMEOUT_LAST)) begin
          state       <= ST_ERROR;
          ctrl_q      <= NOP;
          bus_error_q <= 1'b1;
        end else if (HS) begin
          cnt <= cnt + 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  assign bus.cs_imm_src     = ctrl_q.imm_src;
  assign bus.cs_reg_write   = ctrl_q.reg_write;
  assign bus.cs_reg_1_zero  = ctrl_q.reg_1_zero;
  assign bus.cs_alu_src     = ctrl_q.alu_src;
  assign bus.cs_alu_control = ctrl_q.alu_control;
  assign bus.cs_mem_to_reg  = ctrl_q.mem_to_reg;
  assign bus.cs_branch_op   = ctrl_q.branch_op;
  assign bus.cs_bus_read    = ctrl_q.bus_read;
  assign bus.cs_bus_write   = ctrl_q.bus_write;
  assign bus.cs_stall       = (state != ST_RUN);
  assign bus.cs_illegal     = illegal_q;
  assign bus.cs_bus_error   = bus_error_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: drives three sequencer configurations (fixed stalls,
// handshake with default timeout, handshake with a 4-cycle timeout) with the
// same instruction stream and compares every cycle against a reference model.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  control_sequencer_if if_fix ();
  control_sequencer_if if_hs ();
  control_sequencer_if if_hs4 ();

  control_sequencer #(.BUS_HANDSHAKE(0), .LOAD_STALL_CYCLES(2), .STORE_STALL_CYCLES(1),
                      .TIMEOUT_CYCLES(15), .CNT_W(4))
    u_fix (.clk(clk), .reset(reset), .bus(if_fix));
  control_sequencer #(.BUS_HANDSHAKE(1), .LOAD_STALL_CYCLES(1), .STORE_STALL_CYCLES(0),
                      .TIMEOUT_CYCLES(15), .CNT_W(4))
    u_hs (.clk(clk), .reset(reset), .bus(if_hs));
  control_sequencer #(.BUS_HANDSHAKE(1), .LOAD_STALL_CYCLES(1), .STORE_STALL_CYCLES(0),
                      .TIMEOUT_CYCLES(4), .CNT_W(4))
    u_hs4 (.clk(clk), .reset(reset), .bus(if_hs4));

  // Configuration of each instance, as seen by the model.
  int cfg_hs [3] = '{0, 1, 1};
  int cfg_ld [3] = '{2, 1, 1};
  int cfg_st [3] = '{1, 0, 0};
  int cfg_to [3] = '{15, 15, 4};

  localparam logic [6:0] OP_ARITHR = 7'b0110011;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Decode table: {imm_src, reg_write, reg_1_zero, alu_src, alu_control,
  // mem_to_reg, branch_op, bus_read, bus_write}.
  logic [6:0]  tbl_op   [9] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1100111,
                                7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111};
  logic [13:0] tbl_ctrl [9] = '{14'b000_1_0_0_11_00_00_0_0, 14'b001_1_0_1_10_00_00_0_0,
                                14'b011_0_0_0_01_00_01_0_0, 14'b100_1_1_1_00_10_10_0_0,
                                14'b001_1_0_1_00_10_11_0_0, 14'b001_1_0_1_00_01_00_1_0,
                                14'b010_0_0_1_00_00_00_0_1, 14'b000_1_1_1_00_00_00_0_0,
                                14'b101_1_0_1_00_11_00_0_0};

  // Reference model state per instance.
  logic [13:0] m_ctrl    [3];
  bit          m_ill     [3];
  bit          m_err     [3];
  bit          m_busy    [3];
  int          m_elapsed [3];
  int          m_need    [3];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ctrl[i] = '0; m_ill[i] = 0; m_err[i] = 0;
      m_busy[i] = 0;  m_elapsed[i] = 0; m_need[i] = 0;
    end
  endtask

  task automatic model_take(input int i, input logic [6:0] op, input bit valid, input bit fl);
    bit known = 0;
    m_ctrl[i] = '0;
    m_ill[i]  = 0;
    if (fl || !valid) return;
    for (int k = 0; k < 9; k++)
      if (tbl_op[k] == op) begin known = 1; m_ctrl[i] = tbl_ctrl[k]; end
    if (!known) begin m_ill[i] = 1; return; end
    if (op == OP_LOAD || op == OP_STORE) begin
      m_need[i] = (op == OP_LOAD) ? cfg_ld[i] : cfg_st[i];
      if (cfg_hs[i] != 0 || m_need[i] > 0) begin
        m_busy[i] = 1;
        m_elapsed[i] = 0;
      end
    end
  endtask

  task automatic model_step(input int i, input logic [6:0] op, input bit valid, input bit fl,
                            input bit rdy);
    if (m_err[i]) return;
    if (!m_busy[i]) begin
      model_take(i, op, valid, fl);
      return;
    end
    m_elapsed[i]++;
    if (cfg_hs[i] != 0) begin
      if (rdy) begin
        m_busy[i] = 0;
        model_take(i, op, valid, fl);
      end else if (m_elapsed[i] == cfg_to[i]) begin
        m_busy[i] = 0; m_err[i] = 1; m_ctrl[i] = '0; m_ill[i] = 0;
      end
    end else if (m_elapsed[i] == m_need[i]) begin
      m_busy[i] = 0;
      model_take(i, op, valid, fl);
    end
  endtask

  function automatic logic [16:0] observe(input int i);
    case (i)
      0: return {if_fix.cs_imm_src, if_fix.cs_reg_write, if_fix.cs_reg_1_zero, if_fix.cs_alu_src,
                 if_fix.cs_alu_control, if_fix.cs_mem_to_reg, if_fix.cs_branch_op,
                 if_fix.cs_bus_read, if_fix.cs_bus_write,
                 if_fix.cs_stall, if_fix.cs_illegal, if_fix.cs_bus_error};
      1: return {if_hs.cs_imm_src, if_hs.cs_reg_write, if_hs.cs_reg_1_zero, if_hs.cs_alu_src,
                 if_hs.cs_alu_control, if_hs.cs_mem_to_reg, if_hs.cs_branch_op,
                 if_hs.cs_bus_read, if_hs.cs_bus_write,
                 if_hs.cs_stall, if_hs.cs_illegal, if_hs.cs_bus_error};
      default: return {if_hs4.cs_imm_src, if_hs4.cs_reg_write, if_hs4.cs_reg_1_zero,
                 if_hs4.cs_alu_src, if_hs4.cs_alu_control, if_hs4.cs_mem_to_reg,
                 if_hs4.cs_branch_op, if_hs4.cs_bus_read, if_hs4.cs_bus_write,
                 if_hs4.cs_stall, if_hs4.cs_illegal, if_hs4.cs_bus_error};
    endcase
  endfunction

  task automatic check_all();
    logic [16:0] o;
    for (int i = 0; i < 3; i++) begin
      o = observe(i);
      check($sformatf("dut%0d ctrl", i), 32'(o[16:3]), 32'(m_ctrl[i]));
      check($sformatf("dut%0d stall", i), 32'(o[2]), 32'(m_busy[i] || m_err[i]));
      check($sformatf("dut%0d illegal", i), 32'(o[1]), 32'(m_ill[i]));
      check($sformatf("dut%0d bus_error", i), 32'(o[0]), 32'(m_err[i]));
    end
  endtask

  task automatic drive(input logic [6:0] op, input bit valid, input bit fl,
                       input bit r_fix, input bit r_hs, input bit r_hs4);
    if_fix.opcode = op; if_fix.instr_valid = valid; if_fix.flush = fl; if_fix.bus_ready = r_fix;
    if_hs.opcode  = op; if_hs.instr_valid  = valid; if_hs.flush  = fl; if_hs.bus_ready  = r_hs;
    if_hs4.opcode = op; if_hs4.instr_valid = valid; if_hs4.flush = fl; if_hs4.bus_ready = r_hs4;
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, compare.
  task automatic cycle(input logic [6:0] op, input bit valid, input bit fl,
                       input bit r_fix, input bit r_hs, input bit r_hs4);
    drive(op, valid, fl, r_fix, r_hs, r_hs4);
    @(posedge clk);
    #1;
    model_step(0, op, valid, fl, r_fix);
    model_step(1, op, valid, fl, r_hs);
    model_step(2, op, valid, fl, r_hs4);
    check_all();
  endtask

  // Called 1 time unit after an edge; asserts reset between edges and checks
  // that outputs clear before any further clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [6:0] op;
    bit valid, fl;
    int r;
    reset = 1'b1;
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    cycle(OP_ARITHR, 1, 0, 0, 0, 0);
    cycle(OP_LOAD,   1, 0, 0, 1, 1);
    repeat (3) cycle(OP_ARITHI, 1, 0, 0, 1, 1);
    cycle(OP_SYSTEM, 1, 0, 0, 0, 0);
    cycle(OP_AUIPC,  1, 0, 0, 0, 0);
    cycle(OP_JAL,    1, 1, 0, 0, 0);
    cycle(OP_LOAD,   1, 0, 0, 0, 0);
    cycle(OP_ARITHR, 1, 1, 0, 1, 1);
    repeat (2) cycle(OP_ARITHR, 1, 0, 0, 0, 0);

    do_reset();
    cycle(OP_STORE, 1, 0, 0, 0, 0);
    cycle(OP_ARITHI, 1, 0, 0, 0, 0);
    cycle(OP_ARITHI, 1, 0, 0, 0, 0);
    cycle(OP_ARITHI, 1, 0, 1, 1, 1);
    cycle(OP_LOAD, 1, 0, 0, 0, 0);
    cycle(OP_LOAD, 1, 0, 0, 1, 1);
    cycle(OP_LOAD, 1, 0, 0, 1, 1);
    cycle(OP_ARITHR, 1, 0, 0, 1, 1);

    do_reset();
    cycle(OP_LOAD, 1, 0, 0, 0, 0);
    repeat (6) cycle(OP_ARITHR, 1, 0, 0, 0, 0);
    do_reset();

    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 12);
      if (r < 9) begin
        op = tbl_op[r];
      end else if (r == 9) begin
        op = OP_LOAD;
      end else if (r == 10) begin
        op = OP_STORE;
      end else begin
        op = 7'($urandom);
      end
      valid = ($urandom_range(0, 99) < 85);
      fl    = ($urandom_range(0, 99) < 10);
      cycle(op, valid, fl, 1'($urandom), ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 25));
      if ($urandom_range(0, 99) < 3) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
